// File: rtl/seg_display_mux.sv
// Purpose: four-digit multiplexed 7-segment driver for an MM:SS clock with frame snapshot, anti-ghost blanking and colon.
// Latency: an/seg/dp are registered, one clk after the prescaler, slot index and snapshot they are derived from.
// Backpressure: none; enable=0 freezes cnt/idx/snapshot and blanks the display until enable returns.
//
// Ports:
//   clk, rst (async, active-low)            - clock and reset
//   enable                                  - 1: display runs, 0: hold state and blank
//   pulse                                   - 1 Hz single-cycle tick, only used for colon blink
//   seconds_units/tens, minutes_units/tens  - BCD digits (SIZE bits each)
//   an[3:0]  - active-low anodes, an[0]=seconds_units .. an[3]=minutes_tens
//   seg[6:0] - active-low segments {g,f,e,d,c,b,a}
//   dp       - active-low colon, lit in slot 2
// Optional feature macro: SEG_COLON_BLINK_EN (colon blinks on each pulse instead of staying lit).

module seg_display_mux #(
  parameter int SIZE        = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            pulse,
  input  logic [SIZE-1:0] seconds_units,
  input  logic [SIZE-1:0] seconds_tens,
  input  logic [SIZE-1:0] minutes_units,
  input  logic [SIZE-1:0] minutes_tens,
  output logic [3:0]      an,
  output logic [6:0]      seg,
  output logic            dp
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [SIZE-1:0]  snap_su_q, snap_su_d;
  logic [SIZE-1:0]  snap_st_q, snap_st_d;
  logic [SIZE-1:0]  snap_mu_q, snap_mu_d;
  logic [SIZE-1:0]  snap_mt_q, snap_mt_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tc;
  logic             colon_on;
  logic [SIZE-1:0]  digit;

`ifdef SEG_COLON_BLINK_EN
  logic blink_q, blink_d;
  assign colon_on = blink_q;
`else
  logic unused_pulse;
  assign unused_pulse = pulse;
  assign colon_on     = 1'b1;
`endif

  // BCD to active-low gfedcba; anything above 9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [SIZE-1:0] d);
    logic [6:0] s;
    case (32'(d))
      0:       s = 7'b1000000;
      1:       s = 7'b1111001;
      2:       s = 7'b0100100;
      3:       s = 7'b0110000;
      4:       s = 7'b0011001;
      5:       s = 7'b0010010;
      6:       s = 7'b0000010;
      7:       s = 7'b1111000;
      8:       s = 7'b0000000;
      9:       s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    tc        = enable && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_su_d = snap_su_q;
    snap_st_d = snap_st_q;
    snap_mu_d = snap_mu_q;
    snap_mt_d = snap_mt_q;
    an_d      = 4'b1111;
    seg_d     = 7'b1111111;
    dp_d      = 1'b1;
`ifdef SEG_COLON_BLINK_EN
    blink_d   = blink_q ^ (pulse && enable);
`endif

    if (enable) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
    if (tc) begin
      idx_d = idx_q + 2'd1;
    end
    // Capture all digits together at the end of the last slot so a whole
    // frame always shows one coherent time value.
    if (tc && (idx_q == 2'd3)) begin
      snap_su_d = seconds_units;
      snap_st_d = seconds_tens;
      snap_mu_d = minutes_units;
      snap_mt_d = minutes_tens;
    end

    case (idx_q)
      2'd0:    digit = snap_su_q;
      2'd1:    digit = snap_st_q;
      2'd2:    digit = snap_mu_q;
      default: digit = snap_mt_q;
    endcase

    if (enable) begin
      seg_d = seg_decode(digit);
      // The cycle registered from a terminal count keeps all anodes off so
      // the old segment pattern never bleeds into the next digit.
      if (!tc) begin
        if (!((idx_q == 2'd3) && (snap_mt_q == '0))) begin
          an_d = ~(4'b0001 << idx_q);
        end
        if ((idx_q == 2'd2) && colon_on) begin
          dp_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      snap_su_q <= '0;
      snap_st_q <= '0;
      snap_mu_q <= '0;
      snap_mt_q <= '0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
`ifdef SEG_COLON_BLINK_EN
      blink_q   <= 1'b1;
`endif
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_su_q <= snap_su_d;
      snap_st_q <= snap_st_d;
      snap_mu_q <= snap_mu_d;
      snap_mt_q <= snap_mt_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
`ifdef SEG_COLON_BLINK_EN
      blink_q   <= blink_d;
`endif
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Purpose: directed self-checking bench for seg_display_mux with REFRESH_DIV=4 (16-cycle frames).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: enable toggled directly by the bench to pause the display.

module tb_seg_display_mux;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG4 = 7'b0011001;
  localparam logic [6:0] SEG7 = 7'b1111000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       pulse = 1'b0;
  logic [3:0] su = 4'd7, st = 4'd4, mu = 4'd2, mt = 4'd1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // enabled clock edges since last reset release

  seg_display_mux #(.SIZE(4), .REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pulse(pulse),
    .seconds_units(su), .seconds_tens(st), .minutes_units(mu), .minutes_tens(mt),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic en_s;
    en_s = enable && rst;
    @(posedge clk);
    #1;
    if (en_s) cyc++;
  endtask

  task automatic align_frame();
    while (cyc % 16 != 0) tick();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
    n_checks++; if (seg !== OFF) begin n_fail++; $display("FAIL reset_seg got %b want %b", seg, OFF); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", dp); end
    tick();
    n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_hold_an got %b want 1111", an); end
    rst = 1'b1;
    cyc = 0;
  endtask

  // Two frames from reset: frame 0 shows the zero snapshot, frame 1 the inputs.
  task automatic test_frames();
    logic [6:0] seg_tab [4];
    seg_tab[0] = SEG7; seg_tab[1] = SEG4; seg_tab[2] = SEG2; seg_tab[3] = SEG1;
    for (int e = 1; e <= 32; e++) begin
      int rel, c, s, f;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      tick();
      rel = e - 1; c = rel % 4; s = (rel / 4) % 4; f = rel / 16;
      exp_an  = (c == 3 || (s == 3 && f == 0)) ? 4'b1111 : ~(4'b0001 << s);
      exp_seg = (f == 0) ? SEG0 : seg_tab[s];
      exp_dp  = !(s == 2 && c != 3);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL frame_an edge %0d got %b want %b", e, an, exp_an); end
      if (exp_an != 4'b1111) begin
        n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL frame_seg edge %0d got %b want %b", e, seg, exp_seg); end
      end
      n_checks++; if (dp !== exp_dp) begin n_fail++; $display("FAIL frame_dp edge %0d got %b want %b", e, dp, exp_dp); end
    end
  endtask

  task automatic test_free_run();
    for (int w = 0; w < 4; w++) begin
      int blanks = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (an == 4'b1111) blanks++;
        n_checks++; if ($countones(~an) > 1) begin n_fail++; $display("FAIL onehot_an got %b want at most one low", an); end
      end
      n_checks++; if (blanks != 1) begin n_fail++; $display("FAIL blank_count window %0d got %0d want 1", w, blanks); end
    end
  endtask

  task automatic test_dash();
    align_frame();
    su = 4'd12;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e <= 3) begin
        n_checks++; if (seg !== SEG7) begin n_fail++; $display("FAIL dash_old_seg edge %0d got %b want %b", e, seg, SEG7); end
      end
      if (e >= 17) begin
        n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL dash_an edge %0d got %b want 1110", e, an); end
        n_checks++; if (seg !== DASH) begin n_fail++; $display("FAIL dash_seg edge %0d got %b want %b", e, seg, DASH); end
      end
    end
    su = 4'd7;
  endtask

  task automatic test_enable_pause();
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    exp_an[0] = 4'b1011; exp_an[1] = 4'b1011; exp_an[2] = 4'b1111; exp_an[3] = 4'b0111;
    exp_seg[0] = SEG2;   exp_seg[1] = SEG2;   exp_seg[2] = SEG2;   exp_seg[3] = SEG1;
    align_frame();
    repeat (9) tick();   // now in slot 2, cnt=1
    n_checks++; if (an !== 4'b1011) begin n_fail++; $display("FAIL pause_pre_an got %b want 1011", an); end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL pause_an cycle %0d got %b want 1111", i, an); end
      n_checks++; if (seg !== OFF) begin n_fail++; $display("FAIL pause_seg cycle %0d got %b want %b", i, seg, OFF); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL pause_dp cycle %0d got %b want 1", i, dp); end
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (an !== exp_an[i]) begin n_fail++; $display("FAIL resume_an edge %0d got %b want %b", i, an, exp_an[i]); end
      if (i != 2) begin
        n_checks++; if (seg !== exp_seg[i]) begin n_fail++; $display("FAIL resume_seg edge %0d got %b want %b", i, seg, exp_seg[i]); end
      end
    end
  endtask

  task automatic test_colon();
    align_frame();
    for (int e = 1; e <= 64; e++) begin
      int rel, c, s;
      logic colon_on, exp_dp;
      rel = e - 1; c = rel % 4; s = (rel / 4) % 4;
      pulse = (rel % 32 == 0);
      tick();
      pulse = 1'b0;
`ifdef SEG_COLON_BLINK_EN
      colon_on = ((rel / 32) % 2) == 1;
`else
      colon_on = 1'b1;
`endif
      exp_dp = !(s == 2 && c != 3 && colon_on);
      n_checks++; if (dp !== exp_dp) begin n_fail++; $display("FAIL colon_dp edge %0d got %b want %b", e, dp, exp_dp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_an [5];
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1110; exp_an[2] = 4'b1110; exp_an[3] = 4'b1111; exp_an[4] = 4'b1101;
    align_frame();
    repeat (5) tick();   // slot 1, cnt=1
    n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL mid_pre_an got %b want 1101", an); end
    #3 rst = 1'b0;
    #1;
    n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL mid_rst_an got %b want 1111", an); end
    n_checks++; if (seg !== OFF) begin n_fail++; $display("FAIL mid_rst_seg got %b want %b", seg, OFF); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mid_rst_dp got %b want 1", dp); end
    @(posedge clk);
    #1 rst = 1'b1;
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (an !== exp_an[i]) begin n_fail++; $display("FAIL mid_after_an edge %0d got %b want %b", i, an, exp_an[i]); end
      if (i < 3) begin
        n_checks++; if (seg !== SEG0) begin n_fail++; $display("FAIL mid_after_seg edge %0d got %b want %b", i, seg, SEG0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_free_run();
    test_dash();
    test_enable_pause();
    test_colon();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter SIZE, default 4: width of each BCD digit input.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot; legal range is 2 or more.
REQ-003 Parameter CNT_W, default 16: width of the prescaler counter; must satisfy 2^CNT_W >= REFRESH_DIV.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 enable  input  1  display on when 1; blank and hold when 0.
REQ-007 pulse  input  1  single-cycle 1 Hz tick, used only for colon blink.
REQ-008 seconds_units, seconds_tens, minutes_units, minutes_tens  input  SIZE each  BCD time digits to display.
REQ-009 an  output  4  digit anodes, active-low; an[0] = seconds_units ... an[3] = minutes_tens.
REQ-010 seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  decimal point / colon, active-low.

Function
REQ-012 The prescaler cnt SHALL count 0..REFRESH_DIV-1 while enable=1, then wrap to 0; this last value is the "terminal count".
REQ-013 The slot index idx (0..3) SHALL increment modulo 4 at each terminal count.
REQ-014 At a terminal count with idx=3, all four inputs SHALL be captured into a snapshot register; only snapshot values are displayed, so each frame is consistent.
REQ-015 an, seg and dp SHALL be registered, with 1 clk latency from cnt/idx/snapshot.
REQ-016 Anti-ghost blanking: an SHALL be 4'b1111 for the single cycle following each terminal count.
REQ-017 Outside blanking, exactly one an bit, an[idx], SHALL be low.
REQ-018 Leading-zero rule: when the minutes_tens snapshot is 0, an[3] SHALL stay high during slot 3.
REQ-019 Segment decode, 0..9 (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Input values 10..15 SHALL decode to a dash, 0111111.
REQ-021 When enable=0: cnt, idx and the snapshot SHALL hold; an=1111, seg=1111111 and dp=1 from the next cycle.
REQ-022 When enable returns to 1, counting SHALL resume from the held cnt/idx.
REQ-023 dp SHALL be driven low only in slot 2 (the colon), subject to REQ-028/029; otherwise dp=1.

Reset
REQ-024 While rst=0, without waiting for a clock edge, the block SHALL set cnt=0, idx=0, snapshot=0, an=1111, seg=1111111, dp=1 and blink flag=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, operation SHALL start at slot 0 with cnt=0.
REQ-026 The first frame after reset SHALL display the zero snapshot; new inputs SHALL appear from the second frame.

Configuration
REQ-027 Macro SEG_COLON_BLINK_EN SHALL select the colon behaviour.
REQ-028 With SEG_COLON_BLINK_EN defined: a blink flag SHALL toggle on every cycle with pulse=1 and enable=1, and dp SHALL be low in slot 2 only while the flag=1.
REQ-029 Without SEG_COLON_BLINK_EN: dp SHALL be low in every slot-2 display cycle, no blink flag SHALL exist, and pulse SHALL be ignored (the port remains).

Verification (REFRESH_DIV=4)
REQ-030 Reset, enable=1, inputs mt=1, mu=2, st=4, su=7 -> first 16 cycles show only "0" patterns with an[3] never low; from the second frame, slot 0 shows seg=1111000, slot 1 shows 0011001, slot 2 shows 0100100 and slot 3 shows 1111001.
REQ-031 Free-running check -> an=1111 for exactly 1 cycle in every 4, and no two an bits are ever low together.
REQ-032 seconds_units=12 -> slot 0 shows seg=0111111 (dash).
REQ-033 Drop enable at cnt=1 of slot 2 for 5 cycles -> an=1111 the next cycle; after re-enable, slot 2 runs its remaining 2 counts, then slot 3 follows.
REQ-034 With the macro defined and pulse every 32 cycles -> dp in slot 2 alternates between low and high on successive pulses; without the macro -> dp is low in every slot-2 cycle.
REQ-035 Assert rst mid-slot 1 between clock edges -> an=1111, seg=1111111 and dp=1 immediately; after release, slot 0 begins with cnt=0.
